// File: rtl/grayscale_engine.sv
// grayscale_engine: serial R,G,B bytes -> one gray pixel; out_valid one cycle after the B byte, held (input stalled) until out_ready.
// Define GS_THRESHOLD_EN to add a threshold port that binarises out_data (all-ones when gray >= threshold).
module grayscale_engine #(
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 1024,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              pause,
  output logic              busy,
  output logic              frame_done
`ifdef GS_THRESHOLD_EN
  ,
  input  logic [DATA_W-1:0] threshold
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [DATA_W+9:0] W_R = (DATA_W+10)'(77);
  localparam logic [DATA_W+9:0] W_G = (DATA_W+10)'(150);
  localparam logic [DATA_W+9:0] W_B = (DATA_W+10)'(29);

  state_t             state, state_nxt;
  logic [1:0]         ch_cnt, ch_cnt_nxt;
  logic [CNT_W-1:0]   pix_cnt, pix_cnt_nxt;
  logic               mode_q, mode_nxt;
  logic [DATA_W-1:0]  r_q, g_q;
  logic               cap_r, cap_g, cap_b;
  logic [DATA_W+9:0]  luma_sum;
  logic [DATA_W+1:0]  avg_sum;
  logic [DATA_W-1:0]  gray;
  logic [DATA_W-1:0]  pix_out;
  logic               unused_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch_cnt  <= 2'd0;
      pix_cnt <= '0;
      mode_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch_cnt  <= ch_cnt_nxt;
      pix_cnt <= pix_cnt_nxt;
      mode_q  <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ch_cnt_nxt  = ch_cnt;
    pix_cnt_nxt = pix_cnt;
    mode_nxt    = mode_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    cap_r       = 1'b0;
    cap_g       = 1'b0;
    cap_b       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt   = COLLECT;
          mode_nxt    = mode;
          ch_cnt_nxt  = 2'd0;
          pix_cnt_nxt = '0;
        end
      end
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // Abort outranks a coinciding byte: nothing is captured.
        if (!enable) begin
          state_nxt   = IDLE;
          ch_cnt_nxt  = 2'd0;
          pix_cnt_nxt = '0;
        end else if (in_valid) begin
          case (ch_cnt)
            2'd0: begin
              cap_r      = 1'b1;
              ch_cnt_nxt = 2'd1;
            end
            2'd1: begin
              cap_g      = 1'b1;
              ch_cnt_nxt = 2'd2;
            end
            default: begin
              cap_b      = 1'b1;
              ch_cnt_nxt = 2'd0;
              state_nxt  = EMIT;
            end
          endcase
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (!enable) begin
          state_nxt   = IDLE;
          ch_cnt_nxt  = 2'd0;
          pix_cnt_nxt = '0;
        end else if (out_ready) begin
          pix_cnt_nxt = pix_cnt + CNT_W'(1);
          state_nxt   = (pix_cnt == LAST_PIX) ? DONE : COLLECT;
        end
      end
      DONE: begin
        frame_done  = 1'b1;
        state_nxt   = IDLE;
        ch_cnt_nxt  = 2'd0;
        pix_cnt_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pause = busy && !in_ready;

  // B is consumed straight from in_data so the result registers on the B handshake.
  assign luma_sum = {10'd0, r_q} * W_R + {10'd0, g_q} * W_G + {10'd0, in_data} * W_B;
  assign avg_sum  = {2'd0, r_q} + {1'b0, g_q, 1'b0} + {2'd0, in_data};
  assign gray     = mode_q ? avg_sum[DATA_W+1:2] : luma_sum[DATA_W+7:8];
  assign unused_bits = ^{luma_sum[DATA_W+9:DATA_W+8], luma_sum[7:0], avg_sum[1:0]};

`ifdef GS_THRESHOLD_EN
  assign pix_out = (gray >= threshold) ? {DATA_W{1'b1}} : '0;
`else
  assign pix_out = gray;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      g_q      <= '0;
      out_data <= '0;
    end else begin
      if (cap_r) r_q <= in_data;
      if (cap_g) g_q <= in_data;
      if (cap_b) out_data <= pix_out;
    end
  end

endmodule

// File: tb/tb_grayscale_engine.sv
// Scoreboard bench for grayscale_engine with FRAME_PIXELS=4.
module tb_grayscale_engine;

  localparam int DW = 8;
  localparam int FP = 4;

  logic          clk = 1'b0;
  logic          rst, enable, mode, in_valid, in_ready, out_valid, out_ready;
  logic          pause, busy, frame_done;
  logic [DW-1:0] in_data, out_data;
`ifdef GS_THRESHOLD_EN
  logic [DW-1:0] threshold;
`endif

  int            n_cmp = 0;
  int            n_err = 0;
  int            fd_count = 0;
  logic [DW-1:0] sb[$];

  grayscale_engine #(.DATA_W(DW), .FRAME_PIXELS(FP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .pause(pause), .busy(busy), .frame_done(frame_done)
`ifdef GS_THRESHOLD_EN
    , .threshold(threshold)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] model(input logic m, input int r, input int g, input int b);
    int v;
    if (m == 1'b0) v = (77 * r + 150 * g + 29 * b) >> 8;
    else           v = (r + 2 * g + b) >> 2;
`ifdef GS_THRESHOLD_EN
    v = (v >= int'(threshold)) ? 255 : 0;
`endif
    return v[DW-1:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) tick;
    if (in_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
    tick;
  endtask

  task automatic send_pixel(input logic m, input int r, input int g, input int b);
    sb.push_back(model(m, r, g, b));
    send_byte(8'(r));
    send_byte(8'(g));
    send_byte(8'(b));
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic get_output(output logic [DW-1:0] d, output bit ok);
    out_ready = 1'b1;
    wait_valid(ok);
    d = out_data;
    if (ok) tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    repeat (2) tick;
    n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_cmp++; if (pause !== 1'b0)      begin n_err++; $display("FAIL reset_pause: got %b want 0", pause); end
    n_cmp++; if (out_data !== 8'h00)  begin n_err++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    rst = 1'b0; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_luma;
    logic [DW-1:0] d, e;
    bit ok;
    mode = 1'b0; enable = 1'b1;
    send_pixel(1'b0, 255, 255, 255);
    get_output(d, ok); e = sb.pop_front();
    n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL luma_white: got %0d (valid=%b) want %0d", d, ok, e); end
    mode = 1'b1;
    send_pixel(1'b0, 100, 0, 0);
    get_output(d, ok); e = sb.pop_front();
    n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL luma_red_mode_change: got %0d (valid=%b) want %0d", d, ok, e); end
    send_pixel(1'b0, 17, 200, 90);
    get_output(d, ok); e = sb.pop_front();
    n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL luma_mixed: got %0d (valid=%b) want %0d", d, ok, e); end
    enable = 1'b0; mode = 1'b0;
    tick;
  endtask

  task automatic test_average;
    logic [DW-1:0] d, e;
    bit ok;
    mode = 1'b1; enable = 1'b1;
    send_pixel(1'b1, 100, 50, 10);
    get_output(d, ok); e = sb.pop_front();
    n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL avg_mixed: got %0d (valid=%b) want %0d", d, ok, e); end
    send_pixel(1'b1, 0, 0, 0);
    get_output(d, ok); e = sb.pop_front();
    n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL avg_zero: got %0d (valid=%b) want %0d", d, ok, e); end
    send_pixel(1'b1, 255, 255, 255);
    get_output(d, ok); e = sb.pop_front();
    n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL avg_white: got %0d (valid=%b) want %0d", d, ok, e); end
    enable = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] d, e;
    bit ok;
    mode = 1'b0; enable = 1'b1;
    send_pixel(1'b0, 12, 34, 56);
    out_ready = 1'b0;
    wait_valid(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_valid_timeout: out_valid=%b want 1", out_valid); end
    in_valid = 1'b1; in_data = 8'h5A;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid c%0d: got %b want 1", c, out_valid); end
      n_cmp++; if (out_data !== sb[0]) begin n_err++; $display("FAIL bp_out_data c%0d: got %0d want %0d", c, out_data, sb[0]); end
      n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
      n_cmp++; if (pause !== 1'b1)     begin n_err++; $display("FAIL bp_pause c%0d: got %b want 1", c, pause); end
      tick;
    end
    in_valid = 1'b0;
    get_output(d, ok); e = sb.pop_front();
    n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL bp_release: got %0d (valid=%b) want %0d", d, ok, e); end
    enable = 1'b0;
    tick;
  endtask

  task automatic test_frame_end;
    logic [DW-1:0] d, e;
    bit ok;
    int r, g, b;
    mode = 1'b1; enable = 1'b1;
    for (int p = 0; p < FP - 1; p++) begin
      r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
      send_pixel(1'b1, r, g, b);
      get_output(d, ok); e = sb.pop_front();
      n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL frame_px%0d: got %0d (valid=%b) want %0d", p, d, ok, e); end
    end
    send_pixel(1'b1, 200, 100, 50);
    out_ready = 1'b0;
    wait_valid(ok); e = sb.pop_front();
    n_cmp++; if (!ok || out_data !== e) begin n_err++; $display("FAIL frame_last_px: got %0d (valid=%b) want %0d", out_data, ok, e); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL frame_done_early: got %b want 0", frame_done); end
    n_cmp++; if (busy !== 1'b1)       begin n_err++; $display("FAIL frame_busy_emit: got %b want 1", busy); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    tick;
    n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL frame_done_pulse: got %b want 1", frame_done); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL frame_busy_done: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL frame_valid_done: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL frame_in_ready_done: got %b want 0", in_ready); end
    out_ready = 1'b0; enable = 1'b0;
    tick;
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL frame_done_width: got %b want 0", frame_done); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL frame_busy_after: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    logic [DW-1:0] d, e;
    bit ok;
    bit seen;
    mode = 1'b0; enable = 1'b1;
    send_byte(8'd90);
    send_byte(8'd91);
    in_valid = 1'b0; enable = 1'b0;
    tick;
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick;
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL abort_no_valid: got out_valid=1 want 0"); end
    enable = 1'b1;
    send_pixel(1'b0, 200, 10, 60);
    get_output(d, ok); e = sb.pop_front();
    n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL abort_reenable_R: got %0d (valid=%b) want %0d", d, ok, e); end
    send_pixel(1'b0, 5, 6, 7);
    wait_valid(ok);
    void'(sb.pop_front());
    enable = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_emit_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL abort_emit_busy: got %b want 0", busy); end
    enable = 1'b1;
    send_byte(8'd33);
    send_byte(8'd44);
    in_data = 8'd55; enable = 1'b0;
    tick;
    in_valid = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_on_B_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL abort_on_B_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    mode = 1'b0; enable = 1'b1; out_ready = 1'b1;
    fork
      begin
        for (int p = 0; p < FP; p++) begin
          int r, g, b;
          r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
          sb.push_back(model(1'b0, r, g, b));
          send_byte(8'(r));
          send_byte(8'(g));
          send_byte(8'(b));
        end
        in_valid = 1'b0;
      end
      begin
        int got;
        logic [DW-1:0] e;
        got = 0;
        for (int i = 0; i < 400 && got < FP; i++) begin
          if (out_valid === 1'b1) begin
            e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++; if (out_data !== e) begin n_err++; $display("FAIL b2b_px%0d: got %0d want %0d", got, out_data, e); end
            got++;
            if (got < FP) tick;
          end else begin
            tick;
          end
        end
        if (got < FP) begin
          n_cmp++; n_err++;
          $display("FAIL b2b_timeout: got %0d pixels want %0d", got, FP);
        end
      end
    join
    tick;
    n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL b2b_frame_done: got %b want 1", frame_done); end
    enable = 1'b0; out_ready = 1'b0;
    tick;
  endtask

  task automatic test_reset_midframe;
    logic [DW-1:0] d, e;
    bit ok;
    mode = 1'b0; enable = 1'b1;
    send_byte(8'd50);
    send_byte(8'd60);
    rst = 1'b1;
    tick;
    n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (pause !== 1'b0)      begin n_err++; $display("FAIL rstmid_pause: got %b want 0", pause); end
    n_cmp++; if (out_data !== 8'h00)  begin n_err++; $display("FAIL rstmid_out_data: got %0d want 0", out_data); end
    tick;
    rst = 1'b0; in_valid = 1'b0; mode = 1'b1;
    send_pixel(1'b1, 40, 80, 120);
    get_output(d, ok); e = sb.pop_front();
    n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL rstmid_first_R: got %0d (valid=%b) want %0d", d, ok, e); end
    enable = 1'b0;
    tick;
  endtask

`ifdef GS_THRESHOLD_EN
  task automatic test_threshold;
    logic [DW-1:0] d, e;
    bit ok;
    threshold = 8'd128; mode = 1'b0; enable = 1'b1;
    send_pixel(1'b0, 100, 0, 0);
    get_output(d, ok); e = sb.pop_front();
    n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL thr_low: got %0d (valid=%b) want %0d", d, ok, e); end
    send_pixel(1'b0, 255, 255, 255);
    get_output(d, ok); e = sb.pop_front();
    n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL thr_high: got %0d (valid=%b) want %0d", d, ok, e); end
    enable = 1'b0;
    tick;
  endtask
`endif

  initial begin
`ifdef GS_THRESHOLD_EN
    threshold = 8'd128;
`endif
    test_reset;
    test_luma;
    test_average;
    test_backpressure;
    test_frame_end;
    test_abort;
    test_back_to_back;
    test_reset_midframe;
`ifdef GS_THRESHOLD_EN
    test_threshold;
`endif
    repeat (2) tick;
    n_cmp++; if (fd_count !== 2) begin n_err++; $display("FAIL frame_done_total: got %0d pulses want 2", fd_count); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/grayscale_engine.md
GRAYSCALE_ENGINE -- requirements
Module: grayscale_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per colour channel and per gray output.
REQ-002 SHALL have parameter FRAME_PIXELS, default 1024: pixels per frame, 2 or more.
REQ-003 SHALL have parameter CNT_W, default 16: pixel counter width, with 2^CNT_W >= FRAME_PIXELS.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port enable, input, 1 bit: frame run request, level-sensitive.
REQ-007 SHALL have port mode, input, 1 bit: 0 selects weighted luma, 1 selects fast average.
REQ-008 SHALL have port in_data, input, DATA_W bits: serial channel byte, order R, G, B.
REQ-009 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): input handshake.
REQ-010 SHALL have port out_data, output, DATA_W bits: gray pixel value.
REQ-011 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): output handshake.
REQ-012 SHALL have port pause, output, 1 bit: equals !in_ready while busy, for the upstream buffer.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, EMIT and DONE.
REQ-016 IDLE: when enable=1, SHALL go to COLLECT, latch mode, clear the channel and pixel counters, and set busy=1.
REQ-017 COLLECT: SHALL drive in_ready=1 and accept a byte only when in_valid&&in_ready; a 2-bit channel counter steps R->G->B.
REQ-018 On acceptance of the B byte, SHALL register the gray result, go to EMIT, and assert out_valid on the next cycle (latency 1 cycle).
REQ-019 EMIT: SHALL drive in_ready=0 and hold out_valid and out_data stable until out_ready=1.
REQ-020 On the EMIT handshake, SHALL increment the pixel counter; go to DONE if count==FRAME_PIXELS-1, else go to COLLECT.
REQ-021 DONE: SHALL pulse frame_done for exactly one cycle, clear busy, and return to IDLE; a new frame needs enable=1 in IDLE.
REQ-022 Mode 0 SHALL compute (77*R + 150*G + 29*B) >> 8 using DATA_W+10 bit intermediates, with no overflow.
REQ-023 Mode 1 SHALL compute (R + 2*G + B) >> 2 using DATA_W+2 bit intermediates.
REQ-024 A change of the mode port mid-frame SHALL have no effect until the next frame start.
REQ-025 enable=0 in COLLECT or EMIT SHALL abort: IDLE next cycle, counters cleared, out_valid=0, and no frame_done.
REQ-026 When abort and a handshake coincide, abort SHALL win and the pixel SHALL be discarded.
REQ-027 in_valid while IDLE or DONE SHALL be ignored, with in_ready=0.

Reset
REQ-028 When rst=1 at a clock edge, SHALL set state IDLE and force in_ready, out_valid, out_data, busy, frame_done and pause to 0, overriding all other inputs, including mid-frame.
REQ-029 After reset is released, the first byte accepted SHALL be treated as R.

Configuration
REQ-030 With macro GS_THRESHOLD_EN defined, SHALL add input port threshold (DATA_W bits); out_data SHALL be all-ones if gray >= threshold, else 0, with unchanged latency.
REQ-031 Without GS_THRESHOLD_EN, the threshold port and comparator SHALL be absent and out_data SHALL be the raw gray value.

Verification
REQ-032 Luma: mode=0, R=G=B=255 -> out_data=255; mode=0, R=100, G=0, B=0 -> out_data=30.
REQ-033 Average: mode=1, R=100, G=50, B=10 -> out_data=52; mode=1 with all channels 0 -> out_data=0.
REQ-034 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_data held, in_ready=0 and pause=1 throughout.
REQ-035 Frame end: FRAME_PIXELS=4, four pixels streamed -> frame_done high exactly one cycle, one cycle after the 4th output handshake; then busy=0.
REQ-036 Abort: enable=0 after the G byte -> IDLE next cycle, no out_valid, no frame_done; on re-enable the first byte is taken as R.
REQ-037 Threshold (GS_THRESHOLD_EN): threshold=128 with gray 30 -> out_data=0; gray 255 -> out_data=255.
